// File: rtl/m_axi_read_master.sv
// m_axi_read_master: single-outstanding AXI4 read initiator.
// Accepts one (address, beats-1) request, issues one INCR burst on AR, buffers the
// R beats in an internal FIFO and streams them to the user over a valid/ready port.
// Optional feature macro: RD_RESP_CHECK_EN adds M_AXI_RRESP checking and a sticky
// RD_ERR flag; without it the burst ends on RLAST alone.
module m_axi_read_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int ID_LENGTH       = 4,
  parameter int ID_VALUE        = 0,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic [ID_LENGTH-1:0]  M_AXI_ARID,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic                  M_AXI_RLAST,
  input  logic [ID_LENGTH-1:0]  M_AXI_RID,
`ifdef RD_RESP_CHECK_EN
  input  logic [1:0]            M_AXI_RRESP,
  output logic                  RD_ERR,
`endif
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [7:0]            REQ_LEN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_OUT_VALID,
  input  logic                  DATA_OUT_READY,
  output logic                  BUSY
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_RD} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      araddr_q, araddr_d;
  logic [7:0]                 arlen_q, arlen_d;
  logic [7:0]                 beat_cnt_q, beat_cnt_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];

  logic fifo_full, fifo_empty, push, pop, burst_end;

  // Constant AR attributes: full-width INCR bursts with a fixed ID.
  assign M_AXI_ARSIZE  = 3'($clog2(DATA_WIDTH / 8));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID    = ID_LENGTH'(ID_VALUE);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;

  // FIFO status and handshakes; RREADY only depends on state and count.
  assign fifo_full      = (count_q == CW'(DEPTH));
  assign fifo_empty     = (count_q == '0);
  assign DATA_OUT_VALID = !fifo_empty;
  assign DATA_OUT       = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign push           = M_AXI_RVALID && M_AXI_RREADY;
  assign pop            = DATA_OUT_VALID && DATA_OUT_READY;

  // Burst termination: RLAST, or (with response checking) reaching ARLEN beats.
  always_comb begin
`ifdef RD_RESP_CHECK_EN
    burst_end = M_AXI_RLAST || (beat_cnt_q == arlen_q);
`else
    burst_end = M_AXI_RLAST;
`endif
  end

  // FSM state register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (REQ_VALID)          state_d = S_AR;
      S_AR:    if (M_AXI_ARREADY)      state_d = S_RD;
      S_RD:    if (push && burst_end)  state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // FSM outputs, all decoded from the registered state (plus FIFO count).
  always_comb begin
    REQ_READY     = (state_q == S_IDLE);
    M_AXI_ARVALID = (state_q == S_AR);
    M_AXI_RREADY  = (state_q == S_RD) && !fifo_full;
    BUSY          = (state_q != S_IDLE);
  end

  // Request capture and beat counting.
  always_comb begin
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == S_IDLE && REQ_VALID) begin
      araddr_d = REQ_ADDR;
      arlen_d  = REQ_LEN;
    end
    if (push) beat_cnt_d = burst_end ? 8'd0 : beat_cnt_q + 8'd1;
  end

  // FIFO pointer and occupancy update; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control/datapath registers; reset flushes the FIFO by clearing pointers.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the head is gated by the count.
  always_ff @(posedge M_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= M_AXI_RDATA;
  end

`ifdef RD_RESP_CHECK_EN
  logic rd_err_q, rd_err_d;

  // Sticky error: bad response, early RLAST, or missing RLAST at ARLEN.
  always_comb begin
    rd_err_d = rd_err_q;
    if (push) begin
      if (M_AXI_RRESP != 2'b00)                        rd_err_d = 1'b1;
      if (M_AXI_RLAST && (beat_cnt_q != arlen_q))      rd_err_d = 1'b1;
      if (!M_AXI_RLAST && (beat_cnt_q == arlen_q))     rd_err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) rd_err_q <= 1'b0;
    else                rd_err_q <= rd_err_d;
  end

  assign RD_ERR = rd_err_q;

  // RID is deliberately ignored: mismatching beats are still accepted.
  logic unused_ok;
  assign unused_ok = ^M_AXI_RID;
`else
  // RID is ignored and the beat count only matters for response checking.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_RID, beat_cnt_q};
`endif

endmodule

// File: tb/tb_m_axi_read_master.sv
// Directed bench for m_axi_read_master: table of bursts plus hand sequences
// for back-to-back requests, reset mid-burst and (optionally) response errors.
module tb_m_axi_read_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  araddr;
  logic        arvalid, arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic [31:0] rdata;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [7:0]  req_addr, req_len;
  logic        req_valid, req_ready;
  logic [31:0] dout;
  logic        dout_valid, dout_ready, busy;
`ifdef RD_RESP_CHECK_EN
  logic [1:0]  rresp;
  logic        rd_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_axi_read_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARID(arid),
    .M_AXI_RDATA(rdata), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_RLAST(rlast), .M_AXI_RID(rid),
`ifdef RD_RESP_CHECK_EN
    .M_AXI_RRESP(rresp), .RD_ERR(rd_err),
`endif
    .REQ_ADDR(req_addr), .REQ_LEN(req_len), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .DATA_OUT(dout), .DATA_OUT_VALID(dout_valid), .DATA_OUT_READY(dout_ready),
    .BUSY(busy)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  len;
    int          ar_wait;   // cycles ARREADY held low
    int          stall;     // cycles DATA_OUT_READY held low at start
    logic [31:0] base;      // slave returns base+i on beat i
    logic [7:0]  exp_araddr;
    logic [7:0]  exp_arlen;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req_ready();
    int c = 0;
    while (!req_ready && c < 200) begin tick(); c++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Slave side: present beats back to back, advance on each accepted handshake.
  task automatic slave(input logic [7:0] len, input logic [31:0] base);
    int i = 0;
    int c = 0;
    logic hs;
    while (i <= int'(len) && c < 5000) begin
      rvalid = 1'b1;
      rdata  = base + i;
      rlast  = (i == int'(len));
      hs     = rready;
      tick(); c++;
      if (hs) i++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("slave_all_beats", i, int'(len) + 1);
    chk("busy_after_last", {31'd0, busy}, 32'd0);
  endtask

  // User side: optional initial stall, then pop and check every beat in order.
  task automatic consumer(input logic [7:0] len, input logic [31:0] base, input int stall);
    int j = 0;
    int c = 0;
    logic p;
    dout_ready = 1'b0;
    repeat (stall) tick();
    dout_ready = 1'b1;
    while (j <= int'(len) && c < 5000) begin
      p = dout_valid;
      if (p) chk("data_order", dout, base + j);
      tick(); c++;
      if (p) j++;
    end
    dout_ready = 1'b0;
    chk("consumer_all_beats", j, int'(len) + 1);
  endtask

  // While the consumer stalls long enough, the 16-entry FIFO must fill and stall R.
  task automatic full_watch(input int stall);
    if (stall >= 18) begin
      repeat (17) tick();
      chk("fifo_full_rready", {31'd0, rready}, 32'd0);
      chk("fifo_full_valid", {31'd0, dout_valid}, 32'd1);
      chk("fifo_full_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic run_burst(input vec_t v);
    wait_req_ready();
    req_valid = 1'b1; req_addr = v.addr; req_len = v.len;
    tick();
    req_valid = 1'b0;
    chk("arvalid_lat1", {31'd0, arvalid}, 32'd1);
    chk("araddr", {24'd0, araddr}, {24'd0, v.exp_araddr});
    chk("arlen", {24'd0, arlen}, {24'd0, v.exp_arlen});
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);
    chk("req_ready_ar", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < v.ar_wait; k++) begin
      tick();
      chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      chk("ar_hold_addr", {24'd0, araddr}, {24'd0, v.exp_araddr});
      chk("ar_hold_len", {24'd0, arlen}, {24'd0, v.exp_arlen});
      chk("ar_hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("arvalid_drop", {31'd0, arvalid}, 32'd0);
    fork
      slave(v.len, v.base);
      consumer(v.len, v.base, v.stall);
      full_watch(v.stall);
    join
  endtask

  vec_t vecs[5];
  vec_t post_rst;

  initial begin
    rst_n = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0;
    req_addr = '0; req_len = '0; req_valid = 1'b0; dout_ready = 1'b0;
`ifdef RD_RESP_CHECK_EN
    rresp = 2'b00;
`endif
    // addr, len, ar_wait, stall, base, exp_araddr, exp_arlen
    vecs[0] = '{8'h40, 8'd7,   0, 0,  32'h0,    8'h40, 8'd7};    // basic 8-beat
    vecs[1] = '{8'h80, 8'd3,   5, 0,  32'h100,  8'h80, 8'd3};    // AR backpressure
    vecs[2] = '{8'h10, 8'd31,  0, 30, 32'h200,  8'h10, 8'd31};   // FIFO fills
    vecs[3] = '{8'hFC, 8'd0,   1, 3,  32'hABC0, 8'hFC, 8'd0};    // single beat
    vecs[4] = '{8'h00, 8'd255, 2, 0,  32'h1000, 8'h00, 8'd255};  // max length

    repeat (2) tick();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_araddr", {24'd0, araddr}, 32'd0);
    chk("rst_arlen", {24'd0, arlen}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    for (int n = 0; n < 5; n++) run_burst(vecs[n]);

    // Single beat, then a back-to-back request while data is still in the FIFO.
    wait_req_ready();
    req_valid = 1'b1; req_addr = 8'h08; req_len = 8'd0;
    tick();
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hA0; rlast = 1'b1;
    chk("b2b_rready", {31'd0, rready}, 32'd1);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("b2b_r_to_valid", {31'd0, dout_valid}, 32'd1);
    chk("b2b_first_data", dout, 32'hA0);
    chk("b2b_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = 8'h20; req_len = 8'd0;
    tick();
    req_valid = 1'b0;
    chk("b2b_arvalid", {31'd0, arvalid}, 32'd1);
    chk("b2b_araddr", {24'd0, araddr}, 32'h20);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hB0; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("b2b_head", dout, 32'hA0);
    dout_ready = 1'b1;
    tick();
    chk("b2b_second_valid", {31'd0, dout_valid}, 32'd1);
    chk("b2b_second_data", dout, 32'hB0);
    tick();
    dout_ready = 1'b0;
    chk("b2b_empty", {31'd0, dout_valid}, 32'd0);

`ifdef RD_RESP_CHECK_EN
    // Beat 3 of 4 carries SLVERR: flag rises next cycle and sticks; data still lands.
    wait_req_ready();
    req_valid = 1'b1; req_addr = 8'h50; req_len = 8'd3;
    tick();
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'hE0 + i; rlast = (i == 3);
      rresp = (i == 2) ? 2'b10 : 2'b00;
      tick();
      chk("rd_err_flag", {31'd0, rd_err}, {31'd0, (i >= 2)});
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    consumer(8'd3, 32'hE0, 0);
    chk("rd_err_sticky", {31'd0, rd_err}, 32'd1);
`endif

    // Reset pulsed mid-burst after three beats; outputs drop immediately.
    wait_req_ready();
    req_valid = 1'b1; req_addr = 8'h30; req_len = 8'd7;
    tick();
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = 32'hC0 + i; rlast = 1'b0;
      tick();
    end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("arst_rready", {31'd0, rready}, 32'd0);
    chk("arst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_arlen", {24'd0, arlen}, 32'd0);
    rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    post_rst = '{8'h44, 8'd2, 1, 1, 32'h7000, 8'h44, 8'd2};
    run_burst(post_rst);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends with a summary line.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
